// File: rtl/bgr_pkg.sv
// Shared pixel types and default image geometry for the background-replacement pipeline.
package bgr_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam int unsigned DefDataWidth = $bits(rgb_t);
  localparam int unsigned DefImgWidth  = 640;
  localparam int unsigned DefImgHeight = 480;
  localparam rgb_t        DefBgColor   = '{r: 8'h00, g: 8'h00, b: 8'h00};

endpackage

// File: rtl/pixel_sync_fifo.sv
// Single-clock pixel FIFO with registered storage; the head is read straight from the array,
// so a word written this cycle is not visible until the next one.
module pixel_sync_fifo #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              wr_en_i,
  input  logic [DATA_WIDTH-1:0]             wr_data_i,
  input  logic                              rd_en_i,
  output logic [DATA_WIDTH-1:0]             rd_data_o,
  output logic                              full_o,
  output logic                              empty_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  do_wr, do_rd;

  assign full_o    = (count_q == CntW'(FIFO_DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_rd = rd_en_i & ~empty_o;
  assign do_wr = wr_en_i & (~full_o | do_rd);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/mask_apply.sv
// Pairs raw pixels with raster-ordered mask bits, replacing background pixels and framing rows.
// Optional per-frame foreground counter enabled by defining MASK_APPLY_FG_COUNT_EN.
module mask_apply
  import bgr_pkg::*;
#(
  parameter int unsigned               DATA_WIDTH = DefDataWidth,
  parameter int unsigned               FIFO_DEPTH = 16,
  parameter int unsigned               IMG_WIDTH  = DefImgWidth,
  parameter int unsigned               IMG_HEIGHT = DefImgHeight,
  parameter logic [DATA_WIDTH-1:0]     BG_COLOR   = DATA_WIDTH'(DefBgColor)
) (
  input  logic                         i_CLK,
  input  logic                         i_RST,
  input  logic [DATA_WIDTH-1:0]        i_DATA,
  input  logic                         i_DATA_VALID,
  output logic                         o_DATA_READY,
  input  logic                         i_MASK,
  input  logic                         i_MASK_VALID,
  output logic [DATA_WIDTH-1:0]        o_DATA,
  output logic                         o_VALID,
  output logic                         o_EOL,
  output logic                         o_EOF,
  output logic                         o_OVERFLOW,
  output logic                         o_UNDERFLOW
`ifdef MASK_APPLY_FG_COUNT_EN
  ,
  output logic [$clog2(IMG_WIDTH*IMG_HEIGHT+1)-1:0] o_FG_COUNT,
  output logic                         o_FG_COUNT_VALID
`endif
);

  localparam int unsigned ColW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int unsigned RowW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  logic [DATA_WIDTH-1:0]            fifo_rd_data;
  logic                             fifo_full, fifo_empty, pop;
  logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count;
  logic                             unused_count;

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d, eol_q, eol_d, eof_q, eof_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d;
  logic [ColW-1:0]       col_q, col_d;
  logic [RowW-1:0]       row_q, row_d;
  logic                  last_col, last_row;

  assign pop          = i_MASK_VALID & ~fifo_empty;
  assign unused_count = ^fifo_count;

  pixel_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (i_CLK),
    .rst_i     (i_RST),
    .wr_en_i   (i_DATA_VALID),
    .wr_data_i (i_DATA),
    .rd_en_i   (pop),
    .rd_data_o (fifo_rd_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  assign last_col = (col_q == ColW'(IMG_WIDTH - 1));
  assign last_row = (row_q == RowW'(IMG_HEIGHT - 1));

  always_comb begin
    data_d  = data_q;
    valid_d = 1'b0;
    eol_d   = 1'b0;
    eof_d   = 1'b0;
    col_d   = col_q;
    row_d   = row_q;
    ovf_d   = ovf_q | (i_DATA_VALID & fifo_full & ~pop);
    unf_d   = unf_q | (i_MASK_VALID & fifo_empty);
    if (pop) begin
      data_d  = i_MASK ? fifo_rd_data : BG_COLOR;
      valid_d = 1'b1;
      eol_d   = last_col;
      eof_d   = last_col & last_row;
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + RowW'(1);
      end else begin
        col_d = col_q + ColW'(1);
      end
    end
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      eol_q   <= eol_d;
      eof_q   <= eof_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  assign o_DATA_READY = ~fifo_full;
  assign o_DATA       = data_q;
  assign o_VALID      = valid_q;
  assign o_EOL        = eol_q;
  assign o_EOF        = eof_q;
  assign o_OVERFLOW   = ovf_q;
  assign o_UNDERFLOW  = unf_q;

`ifdef MASK_APPLY_FG_COUNT_EN
  localparam int unsigned FgW = $clog2(IMG_WIDTH * IMG_HEIGHT + 1);

  logic [FgW-1:0] fg_acc_q, fg_acc_d, fg_count_q, fg_count_d, fg_sum;
  logic           fg_valid_q, fg_valid_d;

  // fg_sum already includes the pixel being emitted, so the EOF pixel is counted.
  assign fg_sum = fg_acc_q + FgW'(i_MASK);

  always_comb begin
    fg_acc_d   = fg_acc_q;
    fg_count_d = fg_count_q;
    fg_valid_d = 1'b0;
    if (pop) begin
      fg_acc_d = fg_sum;
      if (last_col && last_row) begin
        fg_count_d = fg_sum;
        fg_acc_d   = '0;
        fg_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      fg_acc_q   <= '0;
      fg_count_q <= '0;
      fg_valid_q <= 1'b0;
    end else begin
      fg_acc_q   <= fg_acc_d;
      fg_count_q <= fg_count_d;
      fg_valid_q <= fg_valid_d;
    end
  end

  assign o_FG_COUNT       = fg_count_q;
  assign o_FG_COUNT_VALID = fg_valid_q;
`endif

endmodule

// File: tb/tb_mask_apply.sv
// Self-checking bench for mask_apply: directed table, corner sequences and a random run
// checked against a queue-based model of the pixel stream.
module tb_mask_apply;

  localparam int unsigned W     = 4;
  localparam int unsigned H     = 2;
  localparam int unsigned Depth = 16;
  localparam logic [23:0] Bg    = 24'h000000;

  logic        clk = 1'b0;
  logic        i_RST = 1'b0;
  logic [23:0] i_DATA = '0;
  logic        i_DATA_VALID = 1'b0;
  logic        o_DATA_READY;
  logic        i_MASK = 1'b0;
  logic        i_MASK_VALID = 1'b0;
  logic [23:0] o_DATA;
  logic        o_VALID, o_EOL, o_EOF, o_OVERFLOW, o_UNDERFLOW;
`ifdef MASK_APPLY_FG_COUNT_EN
  logic [3:0]  o_FG_COUNT;
  logic        o_FG_COUNT_VALID;
`endif

  always #5 clk = ~clk;

  mask_apply #(
    .DATA_WIDTH (24),
    .FIFO_DEPTH (Depth),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .BG_COLOR   (Bg)
  ) dut (
    .i_CLK        (clk),
    .i_RST        (i_RST),
    .i_DATA       (i_DATA),
    .i_DATA_VALID (i_DATA_VALID),
    .o_DATA_READY (o_DATA_READY),
    .i_MASK       (i_MASK),
    .i_MASK_VALID (i_MASK_VALID),
    .o_DATA       (o_DATA),
    .o_VALID      (o_VALID),
    .o_EOL        (o_EOL),
    .o_EOF        (o_EOF),
    .o_OVERFLOW   (o_OVERFLOW),
    .o_UNDERFLOW  (o_UNDERFLOW)
`ifdef MASK_APPLY_FG_COUNT_EN
    ,
    .o_FG_COUNT       (o_FG_COUNT),
    .o_FG_COUNT_VALID (o_FG_COUNT_VALID)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: a queue of buffered pixels and a running output index.
  logic [23:0] pq[$];
  int          out_idx;
  bit          m_ovf, m_unf;
  logic [23:0] e_data;
  bit          e_valid, e_eol, e_eof, e_fgv;
  int          fg_run, e_fgc;

  typedef struct {
    bit          dv;
    logic [23:0] d;
    bit          mv;
    bit          m;
    bit          ev;
    logic [23:0] ed;
    bit          eeol;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    pq.delete();
    out_idx = 0;
    m_ovf   = 0;
    m_unf   = 0;
    e_data  = '0;
    e_valid = 0;
    e_eol   = 0;
    e_eof   = 0;
    e_fgv   = 0;
    fg_run  = 0;
    e_fgc   = 0;
  endtask

  task automatic step(input bit dv, input logic [23:0] d, input bit mv, input bit m);
    int          size0;
    bit          rd;
    logic [23:0] head;
    @(negedge clk);
    i_DATA_VALID = dv;
    i_DATA       = d;
    i_MASK_VALID = mv;
    i_MASK       = m;
    chk("ready", o_DATA_READY, 32'(pq.size() < Depth));
    size0   = pq.size();
    rd      = mv && (size0 > 0);
    e_valid = 0;
    e_eol   = 0;
    e_eof   = 0;
    e_fgv   = 0;
    if (mv && size0 == 0) m_unf = 1;
    if (rd) begin
      head    = pq.pop_front();
      e_data  = m ? head : Bg;
      e_valid = 1;
      e_eol   = (out_idx % W) == W - 1;
      e_eof   = e_eol && ((out_idx / W) % H) == H - 1;
      out_idx++;
      if (m) fg_run++;
      if (e_eof) begin
        e_fgc  = fg_run;
        e_fgv  = 1;
        fg_run = 0;
      end
    end
    if (dv) begin
      if (size0 < Depth || rd) pq.push_back(d);
      else m_ovf = 1;
    end
    @(posedge clk);
    #1;
    chk("valid", o_VALID, 32'(e_valid));
    chk("data", o_DATA, 32'(e_data));
    chk("eol", o_EOL, 32'(e_eol));
    chk("eof", o_EOF, 32'(e_eof));
    chk("overflow", o_OVERFLOW, 32'(m_ovf));
    chk("underflow", o_UNDERFLOW, 32'(m_unf));
`ifdef MASK_APPLY_FG_COUNT_EN
    chk("fg_valid", o_FG_COUNT_VALID, 32'(e_fgv));
    if (e_fgv) chk("fg_count", o_FG_COUNT, 32'(e_fgc));
`endif
  endtask

  // Inputs are held active during reset to show they are ignored.
  task automatic do_reset();
    @(negedge clk);
    i_DATA_VALID = 1'b1;
    i_DATA       = 24'hFFFFFF;
    i_MASK_VALID = 1'b1;
    i_MASK       = 1'b1;
    i_RST        = 1'b1;
    #1;
    chk("rst_valid", o_VALID, 0);
    chk("rst_data", o_DATA, 0);
    chk("rst_eol", o_EOL, 0);
    chk("rst_eof", o_EOF, 0);
    chk("rst_ovf", o_OVERFLOW, 0);
    chk("rst_unf", o_UNDERFLOW, 0);
    chk("rst_ready", o_DATA_READY, 1);
    @(posedge clk);
    #1;
    chk("rst_hold_valid", o_VALID, 0);
    @(negedge clk);
    i_RST        = 1'b0;
    i_DATA_VALID = 1'b0;
    i_DATA       = '0;
    i_MASK_VALID = 1'b0;
    i_MASK       = 1'b0;
    model_clear();
  endtask

  initial begin
    int          n_eol, n_eof;
    bit [7:0]    masks;
    int          pdv, pmv;

    model_clear();
    repeat (2) @(posedge clk);
    do_reset();

    // Pass-through: four pixels, then masks 1,0,1,0.
    tbl[0] = '{1, 24'h112233, 0, 0, 0, 24'h000000, 0};
    tbl[1] = '{1, 24'h223344, 0, 0, 0, 24'h000000, 0};
    tbl[2] = '{1, 24'h334455, 0, 0, 0, 24'h000000, 0};
    tbl[3] = '{1, 24'h445566, 0, 0, 0, 24'h000000, 0};
    tbl[4] = '{0, 24'h000000, 1, 1, 1, 24'h112233, 0};
    tbl[5] = '{0, 24'h000000, 1, 0, 1, 24'h000000, 0};
    tbl[6] = '{0, 24'h000000, 1, 1, 1, 24'h334455, 0};
    tbl[7] = '{0, 24'h000000, 1, 0, 1, 24'h000000, 1};
    tbl[8] = '{0, 24'h000000, 0, 0, 0, 24'h000000, 0};
    foreach (tbl[i]) begin
      step(tbl[i].dv, tbl[i].d, tbl[i].mv, tbl[i].m);
      chk("tbl_valid", o_VALID, 32'(tbl[i].ev));
      chk("tbl_data", o_DATA, 32'(tbl[i].ed));
      chk("tbl_eol", o_EOL, 32'(tbl[i].eeol));
    end

    // Overflow: 17 pixels into a 16-deep FIFO, then drain 16.
    do_reset();
    for (int i = 0; i < 17; i++) step(1, 24'h100000 + 24'(i), 0, 0);
    chk("ovf_ready", o_DATA_READY, 0);
    chk("ovf_flag", o_OVERFLOW, 1);
    for (int i = 0; i < 16; i++) begin
      step(0, '0, 1, 1);
      chk("ovf_order", o_DATA, 32'(24'h100000 + 24'(i)));
    end

    // Underflow: mask on an empty FIFO with a simultaneous pixel.
    step(1, 24'hABCDEF, 1, 1);
    chk("unf_no_out", o_VALID, 0);
    chk("unf_flag", o_UNDERFLOW, 1);
    step(0, '0, 1, 1);
    chk("unf_next_valid", o_VALID, 1);
    chk("unf_next_data", o_DATA, 32'h00ABCDEF);

    // Reset mid-frame with the column counter advanced and pixels buffered.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1, 24'h000200 + 24'(i), 0, 0);
      step(0, '0, 1, 1);
    end
    for (int i = 0; i < 3; i++) step(1, 24'h000300 + 24'(i), 0, 0);
    do_reset();
    step(1, 24'h5A5A5A, 0, 0);
    step(0, '0, 1, 1);
    chk("midrst_valid", o_VALID, 1);
    chk("midrst_data", o_DATA, 32'h005A5A5A);
    chk("midrst_eol", o_EOL, 0);

    // Framing: one 4x2 frame, then the wrap to (0,0).
    do_reset();
    masks = 8'b1100_1011;  // bit i is the mask of pixel i: 1,1,0,1,0,0,1,1
    n_eol = 0;
    n_eof = 0;
    step(1, 24'h010101, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(1, 24'h010101 * 24'(i + 2), 1, masks[i]);
      chk("frm_eol", o_EOL, 32'(i == 3 || i == 7));
      chk("frm_eof", o_EOF, 32'(i == 7));
      if (o_EOL) n_eol++;
      if (o_EOF) n_eof++;
`ifdef MASK_APPLY_FG_COUNT_EN
      if (i == 7) begin
        chk("fg_cnt_frame", o_FG_COUNT, 5);
        chk("fg_cnt_valid", o_FG_COUNT_VALID, 1);
      end
`endif
    end
    chk("frm_n_eol", n_eol, 2);
    chk("frm_n_eof", n_eof, 1);
    step(0, '0, 1, 1);
    chk("frm_wrap_eol", o_EOL, 0);
    chk("frm_wrap_eof", o_EOF, 0);

    // Random traffic in phases biased toward filling and draining.
    do_reset();
    for (int ph = 0; ph < 6; ph++) begin
      pdv = (ph % 2 == 0) ? 85 : 35;
      pmv = (ph % 2 == 0) ? 30 : 85;
      for (int i = 0; i < 80; i++) begin
        step($urandom_range(0, 99) < pdv, 24'($urandom), $urandom_range(0, 99) < pmv,
             1'($urandom));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
